// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path and the datapath muxes.
// Holds the control FSM state encoding, opcode/funct constants, ALU operation
// codes and the select encodings for every datapath mux driven by control_unit.
package cpu_ctrl_pkg;

  // state_dbg exposes these codes directly, so keep the numbering stable.
  typedef enum logic [4:0] {
    StRst      = 5'd0,
    StFetch    = 5'd1,
    StDecode   = 5'd2,
    StRExec    = 5'd3,
    StRWb      = 5'd4,
    StAddi     = 5'd5,
    StIWb      = 5'd6,
    StMemAddr  = 5'd7,
    StLwRd     = 5'd8,
    StLwWb     = 5'd9,
    StSw       = 5'd10,
    StBranch   = 5'd11,
    StJump     = 5'd12,
    StLui      = 5'd13,
    StExcOpc   = 5'd14,
    StExcOvf   = 5'd15,
    StExcRdOpc = 5'd16,
    StExcRdOvf = 5'd17
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;

  // ALUControl
  localparam logic [2:0] AluPassA = 3'b000;
  localparam logic [2:0] AluAdd   = 3'b001;
  localparam logic [2:0] AluSub   = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluCmp   = 3'b111;

  // ALUSrcA
  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcARegA = 2'd1;
  localparam logic [1:0] SrcAMdr = 2'd2;

  // ALUSrcB
  localparam logic [1:0] SrcBRegB  = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  // PCSource
  localparam logic [2:0] PcSrcAlu    = 3'd0;
  localparam logic [2:0] PcSrcAluOut = 3'd1;
  localparam logic [2:0] PcSrcJump   = 3'd2;
  localparam logic [2:0] PcSrcEpc    = 3'd3;
  localparam logic [2:0] PcSrcMem    = 3'd4;

  // MemAdrsSrc
  localparam logic [2:0] MemAdrPc     = 3'd0;
  localparam logic [2:0] MemAdrAluOut = 3'd1;
  localparam logic [2:0] MemAdrExcOpc = 3'd2;
  localparam logic [2:0] MemAdrExcOvf = 3'd3;

  // WriteIn (destination register select)
  localparam logic [1:0] WrRt  = 2'd0;
  localparam logic [1:0] WrRd  = 2'd1;
  localparam logic [1:0] WrR31 = 2'd2;

  // WriteDataSrc
  localparam logic [2:0] WdAluOut = 3'd0;
  localparam logic [2:0] WdMdr    = 3'd1;
  localparam logic [2:0] WdLui    = 3'd2;

  // True for the R-type funct codes this CPU implements.
  function automatic logic is_rtype_funct(input logic [5:0] fn);
    return (fn == FnAdd) || (fn == FnSub) || (fn == FnAnd);
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the CPU datapath.
// Sequences fetch/decode/execute/memory/writeback one step per clock, and
// handles invalid-opcode and overflow exceptions by saving EPC and loading PC
// from a handler vector byte in memory.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   opcode, funct      IR[31:26], IR[5:0]
//   Z, O, ET           ALU zero / overflow / equal flags
//   PCWrite .. EPCWrite  datapath write enables (MemWrRd=1 is a memory write)
//   ALUSrcA/B, ALUControl, PCSource, MemAdrsSrc, WriteIn, WriteDataSrc
//                      datapath mux selects and ALU op (codes in cpu_ctrl_pkg)
//   state_dbg          current state encoding, debug only
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT     = 1,
  parameter int unsigned EXC_OPC_ADDR = 253,
  parameter int unsigned EXC_OVF_ADDR = 254
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Z,
  input  logic       O,
  input  logic       ET,
  output logic       PCWrite,
  output logic       MemWrRd,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       AB_w,
  output logic       ALUOutWrite,
  output logic       EPCWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] PCSource,
  output logic [2:0] MemAdrsSrc,
  output logic [1:0] WriteIn,
  output logic [2:0] WriteDataSrc,
  output logic [4:0] state_dbg
);

  localparam logic [1:0] MemWaitC = MEM_WAIT[1:0];

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       last_wait;

  // Handler vectors live in memory; this block only drives their select codes.
  // Z is not needed by any implemented instruction.
  logic unused_cfg;
  assign unused_cfg = ^{Z, 8'(EXC_OPC_ADDR), 8'(EXC_OVF_ADDR)};

  assign last_wait = (cnt_q == MemWaitC);
  assign state_dbg = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StRst;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  if (last_wait) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRType:     state_d = is_rtype_funct(funct) ? StRExec : StExcOpc;
          OpAddi:      state_d = StAddi;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
          OpLui:       state_d = StLui;
          default:     state_d = StExcOpc;
        endcase
      end
      // and cannot overflow, so O is ignored for it
      StRExec:   state_d = (O && (funct != FnAnd)) ? StExcOvf : StRWb;
      StAddi:    state_d = O ? StExcOvf : StIWb;
      StMemAddr: state_d = (opcode == OpLw) ? StLwRd : StSw;
      StLwRd:    if (last_wait) state_d = StLwWb;
      StExcOpc:  state_d = StExcRdOpc;
      StExcOvf:  state_d = StExcRdOvf;
      StExcRdOpc, StExcRdOvf: if (last_wait) state_d = StFetch;
      StRWb, StIWb, StLwWb, StSw, StBranch, StJump, StLui: state_d = StFetch;
      default:   state_d = StRst;
    endcase

    // Clears on any state change, saturates at MEM_WAIT
    if (state_d != state_q) begin
      cnt_d = 2'd0;
    end else if (last_wait) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Output decode
  always_comb begin
    PCWrite      = 1'b0;
    MemWrRd      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    AB_w         = 1'b0;
    ALUOutWrite  = 1'b0;
    EPCWrite     = 1'b0;
    ALUSrcA      = SrcAPc;
    ALUSrcB      = SrcBRegB;
    ALUControl   = AluPassA;
    PCSource     = PcSrcAlu;
    MemAdrsSrc   = MemAdrPc;
    WriteIn      = WrRt;
    WriteDataSrc = WdAluOut;

    unique case (state_q)
      StFetch: begin
        MemAdrsSrc = MemAdrPc;
        ALUSrcA    = SrcAPc;
        ALUSrcB    = SrcBFour;
        ALUControl = AluAdd;
        if (last_wait) begin
          IRWrite  = 1'b1;
          PCWrite  = 1'b1;
          PCSource = PcSrcAlu;
        end
      end
      StDecode: begin
        // Branch target PC+(imm<<2) is precomputed into ALUOut here
        AB_w        = 1'b1;
        ALUOutWrite = 1'b1;
        ALUSrcA     = SrcAPc;
        ALUSrcB     = SrcBImmSh;
        ALUControl  = AluAdd;
      end
      StRExec: begin
        ALUSrcA     = SrcARegA;
        ALUSrcB     = SrcBRegB;
        ALUOutWrite = 1'b1;
        if (funct == FnSub) begin
          ALUControl = AluSub;
        end else if (funct == FnAnd) begin
          ALUControl = AluAnd;
        end else begin
          ALUControl = AluAdd;
        end
      end
      StRWb: begin
        RegWrite     = 1'b1;
        WriteIn      = WrRd;
        WriteDataSrc = WdAluOut;
      end
      StAddi, StMemAddr: begin
        ALUSrcA     = SrcARegA;
        ALUSrcB     = SrcBImm;
        ALUControl  = AluAdd;
        ALUOutWrite = 1'b1;
      end
      StIWb: begin
        RegWrite     = 1'b1;
        WriteIn      = WrRt;
        WriteDataSrc = WdAluOut;
      end
      StLwRd: MemAdrsSrc = MemAdrAluOut;
      StLwWb: begin
        RegWrite     = 1'b1;
        WriteIn      = WrRt;
        WriteDataSrc = WdMdr;
      end
      StSw: begin
        MemAdrsSrc = MemAdrAluOut;
        MemWrRd    = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = SrcARegA;
        ALUSrcB    = SrcBRegB;
        ALUControl = AluCmp;
        PCSource   = PcSrcAluOut;
        PCWrite    = ((opcode == OpBeq) && ET) || ((opcode == OpBne) && !ET);
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PcSrcJump;
      end
      StLui: begin
        RegWrite     = 1'b1;
        WriteIn      = WrRt;
        WriteDataSrc = WdLui;
      end
      StExcOpc, StExcOvf: begin
        // PC already advanced by 4 in fetch; PC-4 is the faulting instruction
        ALUSrcA    = SrcAPc;
        ALUSrcB    = SrcBFour;
        ALUControl = AluSub;
        EPCWrite   = 1'b1;
      end
      StExcRdOpc, StExcRdOvf: begin
        MemAdrsSrc = (state_q == StExcRdOpc) ? MemAdrExcOpc : MemAdrExcOvf;
        if (last_wait) begin
          PCWrite  = 1'b1;
          PCSource = PcSrcMem;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int unsigned MW = 2;

  // State codes as seen on state_dbg
  localparam logic [4:0] S_RST = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_REXEC = 5'd3;
  localparam logic [4:0] S_RWB = 5'd4, S_ADDI = 5'd5, S_IWB = 5'd6, S_MEMADDR = 5'd7;
  localparam logic [4:0] S_LWRD = 5'd8, S_LWWB = 5'd9, S_SW = 5'd10, S_BRANCH = 5'd11;
  localparam logic [4:0] S_JUMP = 5'd12, S_LUI = 5'd13, S_EXCOPC = 5'd14, S_EXCOVF = 5'd15;
  localparam logic [4:0] S_EXCRDOPC = 5'd16, S_EXCRDOVF = 5'd17;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       Z, O, ET;
  logic       PCWrite, MemWrRd, IRWrite, RegWrite, AB_w, ALUOutWrite, EPCWrite;
  logic [1:0] ALUSrcA, ALUSrcB, WriteIn;
  logic [2:0] ALUControl, PCSource, MemAdrsSrc, WriteDataSrc;
  logic [4:0] state_dbg;

  control_unit #(
    .MEM_WAIT     (MW),
    .EXC_OPC_ADDR (253),
    .EXC_OVF_ADDR (254)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .Z            (Z),
    .O            (O),
    .ET           (ET),
    .PCWrite      (PCWrite),
    .MemWrRd      (MemWrRd),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .AB_w         (AB_w),
    .ALUOutWrite  (ALUOutWrite),
    .EPCWrite     (EPCWrite),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUControl   (ALUControl),
    .PCSource     (PCSource),
    .MemAdrsSrc   (MemAdrsSrc),
    .WriteIn      (WriteIn),
    .WriteDataSrc (WriteDataSrc),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  // {state, PCWrite,MemWrRd,IRWrite,RegWrite,AB_w,ALUOutWrite,EPCWrite,
  //  ALUSrcA, ALUSrcB, ALUControl, PCSource, MemAdrsSrc, WriteIn, WriteDataSrc}
  logic [29:0] got_v;
  assign got_v = {state_dbg, PCWrite, MemWrRd, IRWrite, RegWrite, AB_w, ALUOutWrite, EPCWrite,
                  ALUSrcA, ALUSrcB, ALUControl, PCSource, MemAdrsSrc, WriteIn, WriteDataSrc};

  typedef struct {
    string       name;
    logic [29:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event popped;

  function automatic logic [29:0] ev(input logic [4:0] st, input logic [6:0] en,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic [2:0] pcs,
                                     input logic [2:0] mas, input logic [1:0] wi,
                                     input logic [2:0] wds);
    return {st, en, sa, sb, alu, pcs, mas, wi, wds};
  endfunction

  task automatic push(input string n, input logic [29:0] v);
    exp_t e;
    e.name = n;
    e.v    = v;
    sb_q.push_back(e);
  endtask

  // Monitor: the FSM presents a new output vector every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (got_v !== e.v) begin
          n_bad++;
          $display("FAIL %s @%0t: got %h required %h", e.name, $time, got_v, e.v);
        end
        ->popped;
      end
    end
  end

  task automatic drain();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 1000) begin
      @(popped);
      budget++;
    end
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic o,
                        input logic et);
    opcode = op;
    funct  = fn;
    O      = o;
    ET     = et;
    Z      = 1'b0;
  endtask

  task automatic push_fetch_decode();
    for (int i = 0; i < int'(MW); i++)
      push("fetch", ev(S_FETCH, 7'b0000000, 2'd0, 2'd1, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("fetch_last", ev(S_FETCH, 7'b1010000, 2'd0, 2'd1, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("decode", ev(S_DECODE, 7'b0000110, 2'd0, 2'd3, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
  endtask

  task automatic push_exc(input logic ovf);
    logic [4:0] s1, s2;
    logic [2:0] mas;
    s1  = ovf ? S_EXCOVF : S_EXCOPC;
    s2  = ovf ? S_EXCRDOVF : S_EXCRDOPC;
    mas = ovf ? 3'd3 : 3'd2;
    push("exc_epc", ev(s1, 7'b0000001, 2'd0, 2'd1, 3'b010, 3'd0, 3'd0, 2'd0, 3'd0));
    for (int i = 0; i < int'(MW); i++)
      push("exc_rd", ev(s2, 7'b0000000, 2'd0, 2'd0, 3'b000, 3'd0, mas, 2'd0, 3'd0));
    push("exc_rd_last", ev(s2, 7'b1000000, 2'd0, 2'd0, 3'b000, 3'd4, mas, 2'd0, 3'd0));
  endtask

  localparam logic [29:0] E_RST = 30'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    // Reset held 3 cycles, RST for one cycle after release, then add (O=0)
    reset = 1'b0;
    set_in(6'h00, 6'h20, 1'b0, 1'b0);
    repeat (3) push("rst_hold", E_RST);
    drain();
    @(posedge clock);
    #1 reset = 1'b1;
    push("rst_release", E_RST);
    push_fetch_decode();
    push("add_exec", ev(S_REXEC, 7'b0000010, 2'd1, 2'd0, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("add_wb", ev(S_RWB, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd1, 3'd0));
    drain();

    // add with overflow
    set_in(6'h00, 6'h20, 1'b1, 1'b0);
    push_fetch_decode();
    push("addovf_exec", ev(S_REXEC, 7'b0000010, 2'd1, 2'd0, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push_exc(1'b1);
    drain();

    // and ignores O
    set_in(6'h00, 6'h24, 1'b1, 1'b0);
    push_fetch_decode();
    push("and_exec", ev(S_REXEC, 7'b0000010, 2'd1, 2'd0, 3'b011, 3'd0, 3'd0, 2'd0, 3'd0));
    push("and_wb", ev(S_RWB, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd1, 3'd0));
    drain();

    // sub
    set_in(6'h00, 6'h22, 1'b0, 1'b0);
    push_fetch_decode();
    push("sub_exec", ev(S_REXEC, 7'b0000010, 2'd1, 2'd0, 3'b010, 3'd0, 3'd0, 2'd0, 3'd0));
    push("sub_wb", ev(S_RWB, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd1, 3'd0));
    drain();

    // beq taken / not taken, bne taken
    set_in(6'h04, 6'h00, 1'b0, 1'b1);
    push_fetch_decode();
    push("beq_taken", ev(S_BRANCH, 7'b1000000, 2'd1, 2'd0, 3'b111, 3'd1, 3'd0, 2'd0, 3'd0));
    drain();
    set_in(6'h04, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("beq_not", ev(S_BRANCH, 7'b0000000, 2'd1, 2'd0, 3'b111, 3'd1, 3'd0, 2'd0, 3'd0));
    drain();
    set_in(6'h05, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("bne_taken", ev(S_BRANCH, 7'b1000000, 2'd1, 2'd0, 3'b111, 3'd1, 3'd0, 2'd0, 3'd0));
    drain();

    // addi, then addi with overflow
    set_in(6'h08, 6'h3F, 1'b0, 1'b0);
    push_fetch_decode();
    push("addi_exec", ev(S_ADDI, 7'b0000010, 2'd1, 2'd2, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("addi_wb", ev(S_IWB, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd0, 3'd0));
    drain();
    set_in(6'h08, 6'h00, 1'b1, 1'b0);
    push_fetch_decode();
    push("addiovf_exec", ev(S_ADDI, 7'b0000010, 2'd1, 2'd2, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push_exc(1'b1);
    drain();

    // lw with MW+1 read cycles
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("lw_addr", ev(S_MEMADDR, 7'b0000010, 2'd1, 2'd2, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    for (int i = 0; i <= int'(MW); i++)
      push("lw_rd", ev(S_LWRD, 7'b0000000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd1, 2'd0, 3'd0));
    push("lw_wb", ev(S_LWWB, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd0, 3'd1));
    drain();

    // sw: one write cycle
    set_in(6'h2B, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("sw_addr", ev(S_MEMADDR, 7'b0000010, 2'd1, 2'd2, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("sw_wr", ev(S_SW, 7'b0100000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd1, 2'd0, 3'd0));
    drain();

    // jump, lui
    set_in(6'h02, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("jump", ev(S_JUMP, 7'b1000000, 2'd0, 2'd0, 3'b000, 3'd2, 3'd0, 2'd0, 3'd0));
    drain();
    set_in(6'h0F, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("lui", ev(S_LUI, 7'b0001000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd0, 2'd0, 3'd2));
    drain();

    // invalid opcode, then R-type with unknown funct
    set_in(6'h3F, 6'h20, 1'b0, 1'b0);
    push_fetch_decode();
    push_exc(1'b0);
    drain();
    set_in(6'h00, 6'h21, 1'b0, 1'b0);
    push_fetch_decode();
    push_exc(1'b0);
    drain();

    // lw interrupted by reset in the middle of the read
    set_in(6'h23, 6'h00, 1'b0, 1'b0);
    push_fetch_decode();
    push("lw2_addr", ev(S_MEMADDR, 7'b0000010, 2'd1, 2'd2, 3'b001, 3'd0, 3'd0, 2'd0, 3'd0));
    push("lw2_rd", ev(S_LWRD, 7'b0000000, 2'd0, 2'd0, 3'b000, 3'd0, 3'd1, 2'd0, 3'd0));
    drain();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (got_v !== E_RST) begin
      n_bad++;
      $display("FAIL async_reset @%0t: got %h required %h", $time, got_v, E_RST);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    set_in(6'h02, 6'h00, 1'b0, 1'b0);
    push("rst2_release", E_RST);
    push_fetch_decode();
    push("jump2", ev(S_JUMP, 7'b1000000, 2'd0, 2'd0, 3'b000, 3'd2, 3'd0, 2'd0, 3'd0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle Moore FSM that drives every control wire of the CPU datapath, one step per clock. It decodes the IR opcode/funct fields and the ALU flags. It sequences fetch, decode, execute, memory and writeback, and handles the overflow and invalid-opcode exceptions. It sits directly upstream of the datapath and is instantiated beside it inside CPU.

Parameters:
MEM_WAIT, 1, extra wait cycles after a memory read address is issued, before data is valid (range 0-3)
EXC_OPC_ADDR, 253, byte address holding the invalid-opcode handler vector
EXC_OVF_ADDR, 254, byte address holding the overflow handler vector

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
Z, O, ET  in  1 each  ALU zero, overflow and equal flags (combinational from the ALU)
PCWrite, MemWrRd, IRWrite, RegWrite, AB_w, ALUOutWrite, EPCWrite  out  1 each  write enables (MemWrRd=1 means write)
ALUSrcA  out  2  0=PC, 1=A, 2=MDR
ALUSrcB  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare
PCSource  out  3  0=ALU, 1=ALUOut, 2=jump addr, 3=EPC, 4=mem byte (exception vector)
MemAdrsSrc  out  3  0=PC, 1=ALUOut, 2=EXC_OPC_ADDR, 3=EXC_OVF_ADDR
WriteIn  out  2  dest reg: 0=rt, 1=rd, 2=r31
WriteDataSrc  out  3  0=ALUOut, 1=MDR, 2=imm<<16
state_dbg  out  5  current state encoding (debug only)

Behaviour:
- Moore outputs: every output is a pure function of state and an internal wait counter. Exceptions: the branch PCWrite gating and the overflow transition also use the flags.
- Reset low (any cycle, including mid-instruction): state<=RST, counter<=0, all enables 0, all selects 0. Takes effect asynchronously.
- Reset release: state stays in RST for one clock, then FETCH.
- RST: all enables 0.
- FETCH: MemAdrsSrc=0, MemWrRd=0, ALUSrcA=0, ALUSrcB=1, ALUControl=add.
  - Stays MEM_WAIT+1 cycles.
  - On the last cycle: IRWrite=1, PCWrite=1, PCSource=0 (PC+4).
  - Then DECODE.
- DECODE (1 cycle): AB_w=1; ALUOutWrite=1 with PC+(imm<<2) (branch target). Next state by opcode:
  - 0x00 with funct 0x20/0x22/0x24 -> R_EXEC
  - 0x08 -> ADDI
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x0F -> LUI
  - anything else, including unknown funct -> EXC_OPC
- R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUControl add/sub/and, ALUOutWrite=1.
  - O=1 on add/sub -> EXC_OVF.
  - Otherwise -> R_WB.
- R_WB: RegWrite=1, WriteIn=1, WriteDataSrc=0 -> FETCH.
- ADDI: ALUSrcA=1, ALUSrcB=2, add, ALUOutWrite=1.
  - O=1 -> EXC_OVF.
  - Otherwise -> I_WB (RegWrite=1, WriteIn=0, WriteDataSrc=0) -> FETCH.
- MEM_ADDR: A+imm into ALUOut.
  - lw -> LW_RD: MemAdrsSrc=1, MEM_WAIT+1 cycles -> LW_WB (RegWrite, WriteIn=0, WriteDataSrc=1) -> FETCH.
  - sw -> SW: MemAdrsSrc=1, MemWrRd=1 for exactly 1 cycle -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, compare. PCWrite=1, PCSource=1 iff (beq & ET) or (bne & !ET) -> FETCH.
- JUMP: PCWrite=1, PCSource=2 -> FETCH.
- LUI: RegWrite=1, WriteIn=0, WriteDataSrc=2 -> FETCH.
- EXC_OPC / EXC_OVF (1 cycle): ALUSrcA=0, ALUSrcB=1, sub, EPCWrite=1 (EPC=PC-4 of the faulting instruction). The destination register is never written.
- EXC_RD: MemAdrsSrc=2 or 3, MEM_WAIT+1 cycles. On the last cycle PCWrite=1, PCSource=4 -> FETCH.
- No two write enables that target the same storage are ever asserted in the same cycle.
- MemWrRd=1 only in SW.
- The wait counter is 2 bits. It clears on every state change and saturates (never wraps) at MEM_WAIT.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum
  - opcode and funct constants
  - ALUControl codes
  - mux-select localparams for ALUSrcA/B, PCSource, MemAdrsSrc, WriteIn and WriteDataSrc
- The datapath MUX modules use the same package.
- No sub-module: next-state logic and output decode stay in one always_comb each, plus one sequential block.

Test Plan:
- Reset held low 3 cycles, then released: all enables 0, state_dbg=RST for 1 cycle, then FETCH; IRWrite and PCWrite pulse after exactly MEM_WAIT+1 cycles.
- add (opcode 0, funct 0x20), O=0: sequence FETCH, DECODE, R_EXEC, R_WB, FETCH; RegWrite with WriteIn=1 only in R_WB; total 3+MEM_WAIT+1 cycles.
- add with O=1 forced in R_EXEC: RegWrite never asserted; EPCWrite in EXC_OVF; MemAdrsSrc=3 during EXC_RD; PCWrite with PCSource=4 on its last cycle.
- beq with ET=1, then with ET=0: PCWrite asserted (PCSource=1) only in the first case; both return to FETCH next cycle.
- lw with MEM_WAIT=2: LW_RD lasts 3 cycles with MemAdrsSrc=1, followed by a LW_WB RegWrite pulse. sw: MemWrRd=1 for exactly one cycle.
- opcode 0x3F, and reset dropped mid LW_RD: the first goes to EXC_OPC with EPCWrite. The second drives every enable to 0 immediately, without waiting for a clock edge.
